// File: rtl/cla_nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit carry-look-ahead
// slice, one nibble per cycle, behind valid/ready handshakes on both sides.
module cla_nibble_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [CW-1:0]    count;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       g;
    logic [3:0]       p;
    logic [4:0]       carries;
    logic [3:0]       sum_nib;
    logic [WIDTH-1:0] result_next;
    logic             accept;
    logic             last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (count == CW'(NIB - 1));

    // Shared 4-bit look-ahead slice fed with nibble 'count' and the registered carry.
    always_comb begin
        a_nib = a_reg[{count, 2'b00} +: 4];
        b_nib = b_reg[{count, 2'b00} +: 4];
        g = a_nib & b_nib;
        p = a_nib ^ b_nib;
        carries[0] = carry;
        carries[1] = g[0] | (p[0] & carry);
        carries[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
        carries[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                   | (p[2] & p[1] & p[0] & carry);
        carries[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0])
                   | (p[3] & p[2] & p[1] & p[0] & carry);
        sum_nib = p ^ carries[3:0];
        result_next = result;
        result_next[{count, 2'b00} +: 4] = sum_nib;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            count    <= '0;
            result   <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg    <= a;
                        b_reg    <= sub ? ~b : b;
                        carry    <= sub;
                        count    <= '0;
                        result   <= '0;
                        c_out    <= 1'b0;
                        overflow <= 1'b0;
                        zero     <= 1'b0;
                    end
                end
                RUN: begin
                    result <= result_next;
                    carry  <= carries[4];
                    count  <= count + 1'b1;
                    if (last) begin
                        c_out    <= carries[4];
                        overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                                 && (sum_nib[3] != a_reg[WIDTH-1]);
                        zero     <= (result_next == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Randomised and directed self-checking bench for cla_nibble_serial_adder,
// compared against a plain-arithmetic model of add/subtract and its flags.
module tb_cla_nibble_serial_adder;

    localparam int WIDTH   = 32;
    localparam int NIB     = WIDTH / 4;
    localparam int TIMEOUT = 40;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             overflow;
    logic             zero;

    int checks;
    int errors;

    cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c_out     (c_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: modular add/sub, unsigned carry/no-borrow, signed range overflow.
    function automatic logic [WIDTH+2:0] model(input logic [WIDTH-1:0] ma,
                                               input logic [WIDTH-1:0] mb,
                                               input logic msub);
        longint sa, sb, sr;
        logic [WIDTH-1:0] r;
        logic co, ov, z;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        sr = msub ? (sa - sb) : (sa + sb);
        r  = msub ? (ma - mb) : (ma + mb);
        if (msub) co = (ma >= mb);
        else      co = ((longint'(ma) + longint'(mb)) >= (64'd1 << WIDTH));
        ov = (sr > ((64'sd1 <<< (WIDTH - 1)) - 1)) || (sr < -(64'sd1 <<< (WIDTH - 1)));
        z  = (r == '0);
        return {co, ov, z, r};
    endfunction

    // Drives one operation at a negedge and checks it through to the output handshake.
    task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                          input logic op_sub, input int hold, input bit noise,
                          input string name);
        logic [WIDTH+2:0] exp;
        logic [WIDTH-1:0] mask;
        int cycles;
        exp = model(op_a, op_b, op_sub);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s in_ready before accept got %b expected 1", name, in_ready);
        end
        in_valid = 1'b1;
        a = op_a;
        b = op_b;
        sub = op_sub;
        @(posedge clk);
        @(negedge clk);
        in_valid = noise;
        a = $urandom;
        b = $urandom;
        sub = $urandom_range(0, 1);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s handshake in RUN got in_ready=%b out_valid=%b expected 0 0",
                     name, in_ready, out_valid);
        end
        cycles = 0;
        while (1) begin
            @(negedge clk);
            cycles++;
            if (out_valid === 1'b1 || cycles >= TIMEOUT) break;
            if (cycles < NIB) begin
                mask = {WIDTH{1'b1}} << (4 * cycles);
                checks++;
                if (result !== (exp[WIDTH-1:0] & ~mask)) begin
                    errors++;
                    $display("[TB] FAIL %s partial after %0d cycles got %h expected %h",
                             name, cycles, result, exp[WIDTH-1:0] & ~mask);
                end
            end
        end
        checks++;
        if (cycles != NIB) begin
            errors++;
            $display("[TB] FAIL %s latency got %0d expected %0d", name, cycles, NIB);
            in_valid = 1'b0;
            return;
        end
        for (int i = 0; i <= hold; i++) begin
            checks++;
            if (result !== exp[WIDTH-1:0] || c_out !== exp[WIDTH+2] ||
                overflow !== exp[WIDTH+1] || zero !== exp[WIDTH] ||
                out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s output (a=%h b=%h sub=%b hold %0d) got r=%h c=%b v=%b z=%b ov=%b ir=%b expected r=%h c=%b v=%b z=%b ov=1 ir=0",
                         name, op_a, op_b, op_sub, i, result, c_out, overflow, zero,
                         out_valid, in_ready, exp[WIDTH-1:0], exp[WIDTH+2], exp[WIDTH+1], exp[WIDTH]);
            end
            if (i < hold) @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s after handshake got out_valid=%b in_ready=%b expected 0 1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 ||
            c_out !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state got ir=%b ov=%b r=%h c=%b v=%b z=%b expected 1 0 0 0 0 0",
                     in_ready, out_valid, result, c_out, overflow, zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0, "add_wrap");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0, "add_ovf");
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 0, 1'b0, "sub_borrow");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0, 1'b0, "sub_ovf");
        run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 0, 1'b0, "sub_zero");
    endtask

    task automatic test_back_pressure();
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 5, 1'b1, "back_pressure");
    endtask

    task automatic test_reset_in_run();
        in_valid = 1'b1;
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || result !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_run got ov=%b r=%h ir=%b expected 0 00000000 1",
                     out_valid, result, in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release got ir=%b ov=%b expected 1 0", in_ready, out_valid);
        end
        run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ra, rb;
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: ra = {1'b0, {(WIDTH-1){1'b1}}};
                2: rb = {1'b1, {(WIDTH-1){1'b0}}};
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            run_op($urandom, $urandom, 1'(n % 2), 0, 1'b0, "back_to_back");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_pressure();
        test_reset_in_run();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_nibble_serial_adder.md
Name: cla_nibble_serial_adder

Overview:
- Multi-cycle wide adder/subtractor built around one 4-bit carry-look-ahead slice, reused once per cycle.
- Accepts a WIDTH-bit operand pair over a valid/ready handshake and feeds nibble k plus the registered carry into the slice on cycle k.
- Collects each nibble sum into a result register and returns the carry-out as the next carry-in.
- Sits between the ALU operand register stage and the ALU result mux; trades latency for area.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, number of nibble cycles (derived; not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand pair and sub are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  1 = compute A-B, 0 = compute A+B
- out_valid  output  1  result and flags are valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  sum or difference
- c_out  output  1  carry out of MSB; for sub, 1 = no borrow
- overflow  output  1  two's-complement signed overflow
- zero  output  1  result == 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low on rst_n and sampled only at the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, c_out=0, overflow=0, zero=0, nibble counter=0, carry register=0.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch a into A_reg and sub into sub_reg.
  - Latch B_reg = sub ? ~b : b.
  - Set carry register = sub, counter = 0, and go to RUN.
- FSM RUN:
  - in_ready=0, out_valid=0.
  - Each cycle the slice computes A_reg[4k+3:4k] + B_reg[4k+3:4k] + carry, with k = counter.
  - The 4-bit sum is written to result[4k+3:4k] and the slice carry-out is written to the carry register.
  - Counter increments each cycle.
  - At k = NIB-1 go to DONE.
  - Also on that final cycle: c_out = slice carry-out, and overflow = (A_reg[MSB]==B_reg[MSB]) && (sum MSB != A_reg[MSB]).
- FSM DONE:
  - out_valid=1, in_ready=0.
  - result, c_out, overflow and zero are held stable while out_ready=0.
  - zero is the registered (result==0) of the completed word.
  - On out_valid&out_ready go to IDLE with out_valid=0 next cycle.
- Latency: out_valid rises exactly NIB cycles after the accepting edge, i.e. 8 cycles for WIDTH=32.
- Throughput: at most one operation per NIB+2 cycles. in_ready stays low in RUN and DONE; there is no same-cycle accept during output handshake.
- result register:
  - Cleared to 0 on the accepting edge.
  - Upper nibbles not yet written read 0 during RUN.
  - result is only defined while out_valid=1.
- Inputs a, b and sub are ignored outside the accepting edge. in_valid held high in RUN or DONE has no effect.
- Reset mid-operation (RUN or DONE): the operation is aborted and all registers return to reset values on the next edge. No partial result is presented. in_ready=1 the cycle after reset is released.
- Wrap-around: arithmetic is modulo 2^WIDTH. The carry out of MSB is reported only on c_out and never extends result.

Test Plan:
- WIDTH=32, a=0xFFFFFFFF, b=0x00000001, sub=0 -> after 8 cycles: result=0x00000000, c_out=1, zero=1, overflow=0.
- a=0x7FFFFFFF, b=0x00000001, sub=0 -> result=0x80000000, c_out=0, overflow=1, zero=0.
- a=0x00000005, b=0x00000007, sub=1 -> result=0xFFFFFFFE, c_out=0 (borrow), overflow=0, zero=0.
- a=0x80000000, b=0x00000001, sub=1 -> result=0x7FFFFFFF, c_out=1, overflow=1.
- Back-pressure: complete an add of 0x12345678+0x11111111, hold out_ready=0 for 5 cycles -> result=0x23456789 stable, out_valid=1 and in_ready=0 throughout. Raise out_ready -> in_ready=1 next cycle.
- Reset in RUN: drop rst_n for one edge at counter=3 -> out_valid=0, result=0, in_ready=1 on release. A new op 0x1+0x1 then yields 0x00000002 after 8 cycles.
